// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: bundles the hazard controller's pipeline-field inputs, control outputs and perf counters.
// Latency: none, wires only.
// Backpressure: none of its own; Freeze/Stall_F carry the controller's hold requests back to the datapath.
// Modports: master = datapath side (drives register fields, samples controls); slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1_D, Rs2_D;
    logic [4:0]       Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic             RegWrite_D, Load_D;
    logic             Branch_Taken_E;
    logic             Mem_Req_M, Mem_Ready;
    logic             Stall_F, Enable_D, Clear_D, Clear_E, Freeze;
    logic [1:0]       Fwd_A_E, Fwd_B_E;
    logic [CNT_W-1:0] Stall_Cycles, Flush_Count;

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
        output RegWrite_D, Load_D, Branch_Taken_E, Mem_Req_M, Mem_Ready,
        input  Stall_F, Enable_D, Clear_D, Clear_E, Freeze,
        input  Fwd_A_E, Fwd_B_E, Stall_Cycles, Flush_Count
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
        input  RegWrite_D, Load_D, Branch_Taken_E, Mem_Req_M, Mem_Ready,
        output Stall_F, Enable_D, Clear_D, Clear_E, Freeze,
        output Fwd_A_E, Fwd_B_E, Stall_Cycles, Flush_Count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall / flush / freeze control and EX operand forwarding for a 5-stage pipeline.
// Latency: control and forwarding outputs are combinational in the cycle the hazard is visible; counters update on the next edge.
// Backpressure: Mem_Req_M with Mem_Ready=0 freezes ID-EX..MEM-WB and holds PC / IF-ID until Mem_Ready returns.
// Ports: Clk; Reset_n (async, active-low, also forces the control outputs to their idle values);
//        hz (slave modport): decode/EX/MEM/WB register fields in, pipeline controls, forward selects and counters out.
// Build option: HAZARD_FWD_EN enables EX forwarding; without it RAW hazards stall until the writer has left MEM.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             regwrite_e_q, regwrite_e_d;
    logic             regwrite_m_q, regwrite_m_d;
    logic             regwrite_w_q, regwrite_w_d;
    logic             load_e_q, load_e_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             mem_wait, flush, ld_use, raw_stall;
    logic             stall_f, enable_d, clear_d, clear_e, freeze;
    logic [1:0]       fwd_a, fwd_b;

    // x0 is hardwired to zero, so a zero destination never creates a dependency.
    function automatic logic rd_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

    always_comb begin
        // Once the wait has started the access is known to be outstanding; only Mem_Ready ends it.
        if (state_q == MEM_WAIT) begin
            mem_wait = !hz.Mem_Ready;
        end else begin
            mem_wait = hz.Mem_Req_M && !hz.Mem_Ready;
        end

        ld_use = load_e_q && (rd_match(hz.Rd_E, hz.Rs1_D) || rd_match(hz.Rd_E, hz.Rs2_D));
`ifdef HAZARD_FWD_EN
        raw_stall = 1'b0;
`else
        // No bypass paths: the reader waits until the writer reaches WB (regfile write-through).
        raw_stall = (regwrite_e_q && (rd_match(hz.Rd_E, hz.Rs1_D) || rd_match(hz.Rd_E, hz.Rs2_D)))
                 || (regwrite_m_q && (rd_match(hz.Rd_M, hz.Rs1_D) || rd_match(hz.Rd_M, hz.Rs2_D)));
`endif
        // A branch held in EX during a freeze flushes on the first unfrozen cycle.
        flush = hz.Branch_Taken_E && !mem_wait;

        // state_d is the mode the pipeline occupies this cycle; outputs decode from it.
        state_d = RUN;
        if (mem_wait) begin
            state_d = MEM_WAIT;
        end else if (!flush && (ld_use || raw_stall)) begin
            state_d = LD_STALL;
        end

        stall_f  = 1'b0;
        enable_d = 1'b1;
        clear_d  = 1'b0;
        clear_e  = 1'b0;
        freeze   = 1'b0;
        if (Reset_n) begin
            case (state_d)
                MEM_WAIT: begin
                    freeze   = 1'b1;
                    stall_f  = 1'b1;
                    enable_d = 1'b0;
                end
                LD_STALL: begin
                    stall_f  = 1'b1;
                    enable_d = 1'b0;
                    clear_e  = 1'b1;
                end
                default: begin
                    clear_d = flush;
                    clear_e = flush;
                end
            endcase
        end

        // Shadow control bits track the ID-EX / EX-MEM / MEM-WB registers.
        regwrite_e_d = regwrite_e_q;
        load_e_d     = load_e_q;
        regwrite_m_d = regwrite_m_q;
        regwrite_w_d = regwrite_w_q;
        if (!freeze) begin
            regwrite_e_d = hz.RegWrite_D && !clear_e;
            load_e_d     = hz.Load_D && !clear_e;
            regwrite_m_d = regwrite_e_q;
            regwrite_w_d = regwrite_m_q;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_f && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (clear_d && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= RUN;
            regwrite_e_q <= 1'b0;
            regwrite_m_q <= 1'b0;
            regwrite_w_q <= 1'b0;
            load_e_q     <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            regwrite_e_q <= regwrite_e_d;
            regwrite_m_q <= regwrite_m_d;
            regwrite_w_q <= regwrite_w_d;
            load_e_q     <= load_e_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

`ifdef HAZARD_FWD_EN
    // MEM has the younger result, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic rw_m, input logic [4:0] rd_m,
                                           input logic rw_w, input logic [4:0] rd_w);
        if (rw_m && rd_match(rd_m, rs)) return 2'b10;
        if (rw_w && rd_match(rd_w, rs)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (Reset_n) begin
            fwd_a = fwd_sel(hz.Rs1_E, regwrite_m_q, hz.Rd_M, regwrite_w_q, hz.Rd_W);
            fwd_b = fwd_sel(hz.Rs2_E, regwrite_m_q, hz.Rd_M, regwrite_w_q, hz.Rd_W);
        end
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{hz.Rs1_E, hz.Rs2_E, hz.Rd_W, regwrite_w_q};
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    assign hz.Stall_F      = stall_f;
    assign hz.Enable_D     = enable_d;
    assign hz.Clear_D      = clear_d;
    assign hz.Clear_E      = clear_e;
    assign hz.Freeze       = freeze;
    assign hz.Fwd_A_E      = fwd_a;
    assign hz.Fwd_B_E      = fwd_b;
    assign hz.Stall_Cycles = stall_cnt_q;
    assign hz.Flush_Count  = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed bench for pipeline_hazard_ctrl with hand-computed expectations.
// Latency: inputs driven after the falling edge, outputs sampled 1ns later, state advances on the rising edge.
// Backpressure: Mem_Ready is driven directly to open and close memory waits.
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W = 4;
`ifdef HAZARD_FWD_EN
    localparam logic [1:0] FWD_M = 2'b10;
    localparam logic [1:0] FWD_W = 2'b01;
    localparam logic       NOFWD = 1'b0;
`else
    localparam logic [1:0] FWD_M = 2'b00;
    localparam logic [1:0] FWD_W = 2'b00;
    localparam logic       NOFWD = 1'b1;
`endif
    localparam logic [31:0] SAT = 32'd15;

    logic Clk = 1'b0;
    logic Reset_n;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz_if ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .hz      (hz_if)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic stall_f, input logic enable_d,
                           input logic clear_d, input logic clear_e, input logic freeze);
        chk({tag, "_stall_f"},  hz_if.Stall_F,  stall_f);
        chk({tag, "_enable_d"}, hz_if.Enable_D, enable_d);
        chk({tag, "_clear_d"},  hz_if.Clear_D,  clear_d);
        chk({tag, "_clear_e"},  hz_if.Clear_E,  clear_e);
        chk({tag, "_freeze"},   hz_if.Freeze,   freeze);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall_cycles"}, hz_if.Stall_Cycles, exp_stall);
        chk({tag, "_flush_count"},  hz_if.Flush_Count,  exp_flush);
    endtask

    task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic rw, input logic ld);
        hz_if.Rs1_D = rs1; hz_if.Rs2_D = rs2; hz_if.RegWrite_D = rw; hz_if.Load_D = ld;
    endtask

    task automatic set_e(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        hz_if.Rs1_E = rs1; hz_if.Rs2_E = rs2; hz_if.Rd_E = rd;
    endtask

    task automatic set_mw(input logic [4:0] rd_m, input logic [4:0] rd_w);
        hz_if.Rd_M = rd_m; hz_if.Rd_W = rd_w;
    endtask

    task automatic idle_in();
        set_d(0, 0, 0, 0); set_e(0, 0, 0); set_mw(0, 0);
        hz_if.Branch_Taken_E = 1'b0; hz_if.Mem_Req_M = 1'b0; hz_if.Mem_Ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic drain();
        idle_in();
        repeat (3) tick();
    endtask

    initial begin
        // Reset with every hazard source active: outputs must still sit idle.
        Reset_n = 1'b0;
        idle_in();
        set_d(5, 5, 1, 1); set_e(7, 7, 5); set_mw(7, 7);
        hz_if.Branch_Taken_E = 1'b1; hz_if.Mem_Req_M = 1'b1; hz_if.Mem_Ready = 1'b0;
        #2;
        chk_ctl("rst", 0, 1, 0, 0, 0);
        chk("rst_fwd_a", hz_if.Fwd_A_E, 2'b00);
        chk("rst_fwd_b", hz_if.Fwd_B_E, 2'b00);
        chk_cnt("rst");
        idle_in();
        @(negedge Clk);
        Reset_n = 1'b1;

        // add x3,x1,x2 then sub x0,x3,x1: RAW on x3.
        set_d(1, 2, 1, 0); #1; chk_ctl("raw_a", 0, 1, 0, 0, 0); tick();
        set_e(1, 2, 3); set_d(3, 1, 1, 0); #1;
        chk_ctl("raw_e", NOFWD, !NOFWD, 0, NOFWD, 0); tick();
        set_e(3, 3, 0); set_mw(3, 0); #1;
        chk_ctl("raw_m", NOFWD, !NOFWD, 0, NOFWD, 0);
        chk("raw_m_fwd_a", hz_if.Fwd_A_E, FWD_M);
        chk("raw_m_fwd_b", hz_if.Fwd_B_E, FWD_M);
        tick();
        set_e(0, 0, 0); set_mw(0, 3); #1; chk_ctl("raw_w", 0, 1, 0, 0, 0); tick();
        exp_stall += 2 * NOFWD;
        chk_cnt("raw");
        // Writer of x0 in EX/MEM against x0 readers: never a hazard.
        set_e(0, 0, 0); set_mw(0, 0); set_d(0, 0, 0, 0); #1;
        chk_ctl("x0", 0, 1, 0, 0, 0);
        chk("x0_fwd_a", hz_if.Fwd_A_E, 2'b00);
        tick();

        // lw x5 then add x6,x6,x5: load-use.
        drain();
        set_d(1, 0, 1, 1); #1; chk_ctl("lu_a", 0, 1, 0, 0, 0); tick();
        set_e(1, 0, 5); set_d(6, 5, 1, 0); #1; chk_ctl("lu_e", 1, 0, 0, 1, 0); tick();
        set_e(0, 0, 0); set_mw(5, 0); #1; chk_ctl("lu_m", NOFWD, !NOFWD, 0, NOFWD, 0); tick();
        set_e(6, 5, 6); set_mw(0, 5); #1;
        chk_ctl("lu_w", 0, 1, 0, 0, 0);
        chk("lu_w_fwd_b", hz_if.Fwd_B_E, FWD_W);
        chk("lu_w_fwd_a", hz_if.Fwd_A_E, 2'b00);
        tick();
        exp_stall += 1 + NOFWD;
        chk_cnt("lu");

        // Forwarding priority: writers in both MEM and WB.
        drain();
        set_d(0, 0, 1, 0); tick();
        set_e(0, 0, 7); tick();
        set_e(0, 0, 9); set_mw(7, 0); tick();
        set_e(7, 0, 0); set_mw(7, 7); #1;
        chk("prio_fwd_a", hz_if.Fwd_A_E, FWD_M);
        chk("prio_fwd_b", hz_if.Fwd_B_E, 2'b00);
        tick();
        set_e(0, 0, 0); set_mw(0, 0); #1;
        chk("prio_x0_fwd_a", hz_if.Fwd_A_E, 2'b00);
        tick();

        // Taken branch coincident with a load-use match: flush wins, no stall.
        drain();
        set_d(1, 0, 1, 1); tick();
        set_e(1, 0, 5); set_d(5, 0, 1, 0); hz_if.Branch_Taken_E = 1'b1; #1;
        chk_ctl("br", 0, 1, 1, 1, 0); tick();
        idle_in();
        exp_flush += 1;
        #1; chk_cnt("br");

        // Memory wait of 3 cycles with a taken branch held in EX.
        drain();
        hz_if.Mem_Req_M = 1'b1; hz_if.Mem_Ready = 1'b0; hz_if.Branch_Taken_E = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; chk_ctl($sformatf("mw%0d", i), 1, 0, 0, 0, 1); tick();
        end
        hz_if.Mem_Ready = 1'b1; #1;
        chk_ctl("mw_done", 0, 1, 1, 1, 0); tick();
        idle_in();
        exp_stall += 3; exp_flush += 1;
        #1; chk_cnt("mw");

        // Freeze holds the EX shadow bit: the x3 writer is still in EX afterwards.
        drain();
        set_d(0, 0, 1, 0); tick();
        set_d(3, 0, 0, 0); set_e(0, 0, 3);
        hz_if.Mem_Req_M = 1'b1; hz_if.Mem_Ready = 1'b0; #1;
        chk_ctl("fz", 1, 0, 0, 0, 1); tick();
        hz_if.Mem_Ready = 1'b1; #1;
        chk_ctl("fz_rel", NOFWD, !NOFWD, 0, NOFWD, 0); tick();
        idle_in();
        exp_stall += 1 + NOFWD;
        #1; chk_cnt("fz");
        drain();

        // Reset pulsed in the middle of a memory wait.
        hz_if.Mem_Req_M = 1'b1; hz_if.Mem_Ready = 1'b0; tick();
        #2; Reset_n = 1'b0; #1;
        exp_stall = 0; exp_flush = 0;
        chk_ctl("rst_mid", 0, 1, 0, 0, 0);
        chk_cnt("rst_mid");
        @(negedge Clk);
        Reset_n = 1'b1;
        hz_if.Mem_Req_M = 1'b0; hz_if.Mem_Ready = 1'b0; #1;
        chk("rst_run_freeze", hz_if.Freeze, 1'b0);
        tick();
        #1; chk_cnt("rst_run");
        idle_in();

        // Saturation of both counters (CNT_W=4).
        hz_if.Mem_Req_M = 1'b1; hz_if.Mem_Ready = 1'b0;
        repeat (20) tick();
        idle_in(); #1;
        chk("sat_stall", hz_if.Stall_Cycles, SAT);
        hz_if.Branch_Taken_E = 1'b1;
        repeat (17) tick();
        idle_in(); #1;
        chk("sat_flush", hz_if.Flush_Count, SAT);
        chk("sat_stall_hold", hz_if.Stall_Cycles, SAT);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
